pio_in_capture: RTL



---
 rtl/pio_in_capture_pkg.sv | 24 ++
 rtl/pio_in_capture_if.sv | 25 ++
 rtl/pio_in_capture_debounce.sv | 60 ++++++
 rtl/pio_in_capture.sv | 83 ++++++++
 4 files changed

// File: rtl/pio_in_capture_pkg.sv
// pio_pkg: shared constants for the input PIO.
//   - Avalon register addresses (DATA, DIR/reserved, IRQMASK, EDGECAPTURE)
//   - edge-type encodings for the EDGE_TYPE parameter
//   - edge_qual(): selects which debounced transitions count as captures
package pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int PIO_EDGE_RISE = 0;
    localparam int PIO_EDGE_FALL = 1;
    localparam int PIO_EDGE_ANY  = 2;

    function automatic logic edge_qual(input int edge_type, input logic rise, input logic fall);
        case (edge_type)
            PIO_EDGE_RISE: return rise;
            PIO_EDGE_FALL: return fall;
            default:       return rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/pio_in_capture_if.sv
// pio_in_capture_if: Avalon-MM slave bus for the input PIO.
//   address    2      register select
//   chipselect 1      slave select
//   write_n    1      active-low write strobe
//   writedata  WIDTH  write data
//   readdata   WIDTH  read data (driven by the slave, zero-wait)
interface pio_in_capture_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pio_in_capture_debounce.sv
// pio_debounce: one input bit -- 2-flop synchroniser, stability counter and
// debounced level, plus single-cycle rise/fall strobes.
//   clk, reset  system clock, synchronous active-high reset
//   din_i       asynchronous input bit
//   stable_o    debounced level (registered)
//   rise_o      stable_q is going 0->1 on the coming clk edge
//   fall_o      stable_q is going 1->0 on the coming clk edge
module pio_debounce #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_BIT        = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where sync2 agrees with the accepted level restarts the count,
    // so only an uninterrupted run of DEBOUNCE_CYCLES disagreements is accepted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= IDLE_BIT;
            sync2_q  <= IDLE_BIT;
            stable_q <= IDLE_BIT;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Strobes look ahead at stable_d so the capture register sets on the same
    // edge that the debounced level changes.
    assign stable_o = stable_q;
    assign rise_o   = !stable_q &&  stable_d;
    assign fall_o   =  stable_q && !stable_d;

endmodule

// File: rtl/pio_in_capture.sv
// pio_in_capture: Avalon-MM input PIO with per-bit debounce, sticky edge
// capture and maskable level interrupt.
//   clk, reset  system clock, synchronous active-high reset
//   bus         Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port     asynchronous external inputs
//   irq         |(EDGECAPTURE & IRQMASK), level interrupt
// Registers: 0 DATA (ro), 1 reserved (reads 0), 2 IRQMASK (rw),
//            3 EDGECAPTURE (read, write-1-to-clear)
module pio_in_capture
    import pio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    pio_in_capture_if.slave  bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] stable, rise, fall, edge_hit;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic             wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_BIT        (IDLE_LEVEL[i])
        ) u_db (
            .clk      (clk),
            .reset    (reset),
            .din_i    (in_port[i]),
            .stable_o (stable[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

    assign wr_en = bus.chipselect && !bus.write_n;

    always_comb begin
        edge_hit = '0;
        for (int i = 0; i < WIDTH; i++)
            edge_hit[i] = edge_qual(EDGE_TYPE, rise[i], fall[i]);
    end

    // Clear is applied before set so a same-cycle new edge survives the clear.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && bus.address == PIO_ADDR_IRQMASK)
            irqmask_d = bus.writedata;
        if (wr_en && bus.address == PIO_ADDR_EDGECAP)
            edgecap_d = edgecap_q & ~bus.writedata;
        edgecap_d = edgecap_d | edge_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            PIO_ADDR_DATA:    bus.readdata = stable;
            PIO_ADDR_IRQMASK: bus.readdata = irqmask_q;
            PIO_ADDR_EDGECAP: bus.readdata = edgecap_q;
            default:          bus.readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule
